gray_dec: RTL and testbench

GRAY_DEC -- requirements
Module: gray_dec

---
 rtl/gray_pkg.sv | 13 +
 rtl/gray2bin.sv | 17 +
 rtl/gray_dec.sv | 96 +++++++++
 tb/tb_gray_dec.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-code count decoder.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    FAULT
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 3;
  localparam int unsigned WRAPCNT_W     = 8;

endpackage

// File: rtl/gray2bin.sv
// Purely combinational Gray-to-binary converter, WIDTH bits wide.
module gray2bin #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Prefix XOR from the MSB downward: each binary bit folds in all higher Gray bits.
  always_comb begin
    bin = gray;
    for (int unsigned k = 1; k < WIDTH; k++) begin
      bin[WIDTH-1-k] = bin[WIDTH-k] ^ gray[WIDTH-1-k];
    end
  end

endmodule

// File: rtl/gray_dec.sv
// Gray-code count tracker: decodes sampled Gray values, follows the count,
// flags roll-overs (Wrap/WrapCnt) and illegal steps (Err).
// Optional feature: define GRAY_DEC_STICKY_ERR_EN to make Err sticky until Reset.
module gray_dec
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Valid,
  input  logic [WIDTH-1:0]     Gray,
  output logic [WIDTH-1:0]     Bin,
  output logic                 Locked,
  output logic                 Wrap,
  output logic                 Err,
  output logic [WRAPCNT_W-1:0] WrapCnt
);

  state_t           state;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] delta;
  logic             step_wrap;
  logic             step_bad;

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray (Gray),
    .bin  (dec)
  );

  // Classify the incoming sample relative to the current reference while tracking.
  always_comb begin
    delta     = dec - Bin;
    step_wrap = 1'b0;
    step_bad  = 1'b0;
    if (Valid && (state == TRACK)) begin
      if (delta == WIDTH'(1)) begin
        step_wrap = (dec == '0);
      end else if (delta != '0) begin
        step_bad = 1'b1;
      end
    end
  end

  // FSM plus all registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      Bin     <= '0;
      Locked  <= 1'b0;
      Wrap    <= 1'b0;
      Err     <= 1'b0;
      WrapCnt <= '0;
    end else begin
      Wrap <= step_wrap;
`ifdef GRAY_DEC_STICKY_ERR_EN
      if (step_bad) begin
        Err <= 1'b1;
      end
`else
      Err <= step_bad;
`endif
      if (step_wrap && (WrapCnt != '1)) begin
        WrapCnt <= WrapCnt + 1'b1;
      end
      if (Valid) begin
        case (state)
          IDLE: begin
            Bin    <= dec;
            state  <= TRACK;
            Locked <= 1'b1;
          end
          TRACK: begin
            if (step_bad) begin
              Bin    <= dec;
              state  <= FAULT;
              Locked <= 1'b0;
            end else if (delta == WIDTH'(1)) begin
              Bin <= dec;
            end
          end
          FAULT: begin
            Bin    <= dec;
            state  <= TRACK;
            Locked <= 1'b1;
          end
          default: begin
            state  <= IDLE;
            Locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_dec.sv
// Self-checking bench for gray_dec (WIDTH=3): directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_gray_dec;

  localparam int W    = 3;
  localparam int N    = 1 << W;
  localparam int MASK = N - 1;
`ifdef GRAY_DEC_STICKY_ERR_EN
  localparam int STICKY = 1;
`else
  localparam int STICKY = 0;
`endif

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Valid;
  logic [W-1:0] Gray;
  logic [W-1:0] Bin;
  logic         Locked;
  logic         Wrap;
  logic         Err;
  logic [7:0]   WrapCnt;

  int vectors = 0;
  int miscompares = 0;

  gray_dec #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Valid   (Valid),
    .Gray    (Gray),
    .Bin     (Bin),
    .Locked  (Locked),
    .Wrap    (Wrap),
    .Err     (Err),
    .WrapCnt (WrapCnt)
  );

  always #5 Clk = ~Clk;

  // Reference: Gray code of a count, and its inverse built by table lookup.
  function automatic int enc(input int b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  int inv_tab [N];
  initial for (int b = 0; b < N; b++) inv_tab[enc(b)] = b;

  // Behavioural model: 0 = no reference, 1 = tracking, 2 = fault.
  int m_mode = 0;
  int m_bin  = 0;
  int m_wrap = 0;
  int m_err  = 0;
  int m_cnt  = 0;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_mode = 0; m_bin = 0; m_wrap = 0; m_err = 0; m_cnt = 0;
    end else begin
      int d;
      int step;
      m_wrap = 0;
      if (STICKY == 0) m_err = 0;
      if (Valid) begin
        d = inv_tab[int'(Gray)];
        if (m_mode == 1) begin
          step = (d - m_bin + N) % N;
          if (step == 1) begin
            if (m_bin == MASK && d == 0) begin
              m_wrap = 1;
              if (m_cnt < 255) m_cnt = m_cnt + 1;
            end
            m_bin = d;
          end else if (step != 0) begin
            m_bin  = d;
            m_mode = 2;
            m_err  = 1;
          end
        end else begin
          m_bin  = d;
          m_mode = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    chk("model_bin",    int'(Bin),     m_bin);
    chk("model_locked", int'(Locked),  (m_mode == 1) ? 1 : 0);
    chk("model_wrap",   int'(Wrap),    m_wrap);
    chk("model_err",    int'(Err),     m_err);
    chk("model_cnt",    int'(WrapCnt), m_cnt);
    if (Wrap === 1'b1 && Err === 1'b1) chk("wrap_err_excl", 1, 0);
  end

  task automatic step(input logic v, input int b);
    Valid = v;
    Gray  = W'(enc(b));
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all(input string name, input int b, input int l, input int w,
                         input int e, input int c);
    chk({name, "_bin"},    int'(Bin),     b);
    chk({name, "_locked"}, int'(Locked),  l);
    chk({name, "_wrap"},   int'(Wrap),    w);
    chk({name, "_err"},    int'(Err),     e);
    chk({name, "_cnt"},    int'(WrapCnt), c);
  endtask

  initial begin
    Reset = 1'b1;
    Valid = 1'b0;
    Gray  = '0;
    #2 Reset = 1'b0;
    @(posedge Clk); @(posedge Clk); #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    Reset = 1'b1;

    // Full count cycle 0..7,0 with one wrap.
    for (int i = 0; i <= N; i++) begin
      step(1'b1, i % N);
      chk("seq_bin", int'(Bin), i % N);
      chk("seq_wrap", int'(Wrap), (i == N) ? 1 : 0);
      chk("seq_err", int'(Err), 0);
    end
    chk("seq_cnt", int'(WrapCnt), 1);

    // Stalls at Bin=2 are legal.
    step(1'b1, 1);
    step(1'b1, 2);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2);
      chk_all("stall", 2, 1, 0, 0, 1);
    end
    step(1'b1, 3);
    chk_all("stall_exit", 3, 1, 0, 0, 1);

    // Illegal step 1 -> 4, then resync at 5.
    Reset = 1'b0; #1; Reset = 1'b1;
    step(1'b1, 1);
    chk_all("fault_ref", 1, 1, 0, 0, 0);
    step(1'b1, 4);
    chk_all("fault_hit", 4, 0, 0, 1, 0);
    step(1'b1, 5);
    chk_all("fault_resync", 5, 1, 0, STICKY, 0);

    // Valid low with changing Gray: everything holds.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, $urandom_range(0, MASK));
      chk_all("hold", 5, 1, 0, STICKY, 0);
    end

    // Asynchronous reset between edges.
    #2 Reset = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0);
    @(posedge Clk); #1 Reset = 1'b1;
    step(1'b1, 4);
    chk_all("post_rst", 4, 1, 0, 0, 0);

    // WrapCnt saturation over 256 wraps.
    Reset = 1'b0; #1; Reset = 1'b1;
    step(1'b1, 0);
    for (int k = 1; k <= 256; k++) begin
      for (int b = 1; b <= N; b++) step(1'b1, b % N);
      if (k >= 254) begin
        chk("sat_wrap", int'(Wrap), 1);
        chk("sat_cnt", int'(WrapCnt), (k < 255) ? k : 255);
      end
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      int dlt;
      if ($urandom_range(0, 99) < 2) begin
        Reset = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
      end else begin
        r = $urandom_range(0, 9);
        if (r < 2)      dlt = 0;
        else if (r < 8) dlt = 1;
        else            dlt = $urandom_range(0, MASK);
        step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, (m_bin + dlt) & MASK);
      end
    end

    @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
